// File: rtl/wb_writeback_pipe_if.sv
// MEM-to-writeback bundle interface.
// One valid bit per lane; a single ready covers the whole bundle.
interface wb_writeback_pipe_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [LANES-1:0]        in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_result;
    logic [LANES*DATA_W-1:0] in_pc;
    logic [LANES*REG_AW-1:0] in_dest;
    logic [LANES-1:0]        in_write_en;
    logic [LANES-1:0]        in_branch_link;

    modport master (
        output in_valid,
        output in_result,
        output in_pc,
        output in_dest,
        output in_write_en,
        output in_branch_link,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_result,
        input  in_pc,
        input  in_dest,
        input  in_write_en,
        input  in_branch_link,
        output in_ready
    );
endinterface

// File: rtl/wb_writeback_pipe.sv
// Multi-lane writeback stage: one-deep bundle register feeding
// the register-file write ports, plus a retired-instruction counter.
module wb_writeback_pipe #(
    parameter int LANES       = 2,
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 8,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_writeback_pipe_if.slave      in_bus,
    input  logic                    flush,
    input  logic                    rf_stall,
    output logic [LANES-1:0]        reg_write_en,
    output logic [LANES*REG_AW-1:0] reg_write_dest,
    output logic [LANES*DATA_W-1:0] reg_write_data,
    output logic [CNT_W-1:0]        retired_count
);

    logic                    stage_valid;
    logic [LANES-1:0]        h_valid;
    logic [LANES-1:0]        h_we;
    logic [LANES-1:0]        h_bl;
    logic [LANES*DATA_W-1:0] h_result;
    logic [LANES*DATA_W-1:0] h_pc;
    logic [LANES*REG_AW-1:0] h_dest;

    logic                    accept;
    logic                    drain;
    logic [LANES-1:0]        want;
    logic [LANES-1:0]        keep;
    logic [CNT_W-1:0]        pop;

    assign in_bus.in_ready = !stage_valid || !rf_stall;
    assign accept = in_bus.in_ready && (|in_bus.in_valid) && !flush;
    assign drain  = stage_valid && !rf_stall && !flush;

    // Resolve each held lane: link override, then zero/invalid gating.
    always_comb begin
        reg_write_dest = '0;
        reg_write_data = '0;
        want           = '0;
        for (int i = 0; i < LANES; i++) begin
            if (h_bl[i]) begin
                reg_write_dest[i*REG_AW +: REG_AW] = REG_AW'(LINK_REG);
                reg_write_data[i*DATA_W +: DATA_W] =
                    h_pc[i*DATA_W +: DATA_W] + DATA_W'(LINK_OFFSET);
                want[i] = 1'b1;
            end else begin
                reg_write_dest[i*REG_AW +: REG_AW] = h_dest[i*REG_AW +: REG_AW];
                reg_write_data[i*DATA_W +: DATA_W] = h_result[i*DATA_W +: DATA_W];
                want[i] = h_we[i];
            end
            if (!h_valid[i] || reg_write_dest[i*REG_AW +: REG_AW] == '0) begin
                want[i] = 1'b0;
            end
        end
    end

    // Same-destination conflict: the younger (higher) lane wins.
    always_comb begin
        keep = want;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (want[i] && want[j] &&
                    reg_write_dest[i*REG_AW +: REG_AW] ==
                    reg_write_dest[j*REG_AW +: REG_AW]) begin
                    keep[i] = 1'b0;
                end
            end
        end
    end

    // Count held valid lanes, written or not.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + CNT_W'(h_valid[i]);
        end
    end

    // Enables are held off while reset is asserted, even before the edge.
    assign reg_write_en = {LANES{rst && drain}} & keep;

    // Bundle register and retired counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_valid   <= 1'b0;
            h_valid       <= '0;
            h_we          <= '0;
            h_bl          <= '0;
            h_result      <= '0;
            h_pc          <= '0;
            h_dest        <= '0;
            retired_count <= '0;
        end else begin
            if (accept) begin
                stage_valid <= 1'b1;
                h_valid     <= in_bus.in_valid;
                h_we        <= in_bus.in_write_en;
                h_bl        <= in_bus.in_branch_link;
                h_result    <= in_bus.in_result;
                h_pc        <= in_bus.in_pc;
                h_dest      <= in_bus.in_dest;
            end else if (drain || flush) begin
                stage_valid <= 1'b0;
            end
            if (drain) begin
                retired_count <= retired_count + pop;
            end
        end
    end

endmodule

// File: tb/tb_wb_writeback_pipe.sv
// Scoreboard bench for wb_writeback_pipe (LANES=2, CNT_W=4).
// Stimulus pushes expected writes; a negedge monitor pops and compares.
module tb_wb_writeback_pipe;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  d0;
        logic [4:0]  d1;
        logic [31:0] r0;
        logic [31:0] r1;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic rf_stall;
    logic [LANES-1:0]        reg_write_en;
    logic [LANES*REG_AW-1:0] reg_write_dest;
    logic [LANES*DATA_W-1:0] reg_write_data;
    logic [CNT_W-1:0]        retired_count;

    wb_writeback_pipe_if #(
        .LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW)
    ) bus ();

    wb_writeback_pipe #(
        .LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW),
        .LINK_REG(31), .LINK_OFFSET(8), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_bus         (bus.slave),
        .flush          (flush),
        .rf_stall       (rf_stall),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .retired_count  (retired_count)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_cnt = 4'd0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid       = '0;
        bus.in_write_en    = '0;
        bus.in_branch_link = '0;
        bus.in_result      = '0;
        bus.in_pc          = '0;
        bus.in_dest        = '0;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [1:0] bl,
                         input logic [4:0] d0, input logic [4:0] d1,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] p0, input logic [31:0] p1);
        bus.in_valid       = v;
        bus.in_write_en    = we;
        bus.in_branch_link = bl;
        bus.in_dest        = {d1, d0};
        bus.in_result      = {r1, r0};
        bus.in_pc          = {p1, p0};
    endtask

    task automatic expect_wr(input logic [1:0] en,
                             input logic [4:0] d0, input logic [4:0] d1,
                             input logic [31:0] r0, input logic [31:0] r1);
        exp_t e;
        e.en = en; e.d0 = d0; e.d1 = d1; e.r0 = r0; e.r1 = r1;
        if (en != 2'b00) q.push_back(e);
    endtask

    // Drive one bundle that is accepted at the next edge and later drains.
    task automatic send(input logic [1:0] v, input logic [1:0] we,
                        input logic [1:0] bl,
                        input logic [4:0] d0, input logic [4:0] d1,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] xen,
                        input logic [4:0] xd0, input logic [4:0] xd1,
                        input logic [31:0] xr0, input logic [31:0] xr1);
        drive(v, we, bl, d0, d1, r0, r1, p0, p1);
        expect_wr(xen, xd0, xd1, xr0, xr1);
        exp_cnt += 4'(v[0]) + 4'(v[1]);
        step();
    endtask

    // Monitor: every cycle with any write enable pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (|reg_write_en) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: en %b dest %h data %h",
                             reg_write_en, reg_write_dest, reg_write_data);
                end else begin
                    e = q.pop_front();
                    chk("wr_en", 32'(reg_write_en), 32'(e.en));
                    if (e.en[0]) begin
                        chk("wr_dest0", 32'(reg_write_dest[4:0]), 32'(e.d0));
                        chk("wr_data0", reg_write_data[31:0], e.r0);
                    end
                    if (e.en[1]) begin
                        chk("wr_dest1", 32'(reg_write_dest[9:5]), 32'(e.d1));
                        chk("wr_data1", reg_write_data[63:32], e.r1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        rf_stall = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_en", 32'(reg_write_en), 32'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cnt", 32'(retired_count), 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        step();

        // single lane write
        send(2'b01, 2'b01, 2'b00, 5'd5, 5'd0, 32'h1234, 32'h0, 32'h0, 32'h0,
             2'b01, 5'd5, 5'd0, 32'h1234, 32'h0);
        idle();
        step();
        chk("cnt_single", 32'(retired_count), 32'(exp_cnt));

        // branch-link back-to-back, including PC wrap
        send(2'b10, 2'b00, 2'b10, 5'd0, 5'd7, 32'h0, 32'h99, 32'h0, 32'h8000_0010,
             2'b10, 5'd0, 5'd31, 32'h0, 32'h8000_0018);
        send(2'b10, 2'b00, 2'b10, 5'd0, 5'd7, 32'h0, 32'h99, 32'h0, 32'hFFFF_FFFC,
             2'b10, 5'd0, 5'd31, 32'h0, 32'h0000_0004);
        idle();
        step();
        chk("cnt_link", 32'(retired_count), 32'(exp_cnt));

        // conflict, zero dest, link vs write conflict, dual write, invalid lane
        send(2'b11, 2'b11, 2'b00, 5'd9, 5'd9, 32'hA, 32'hB, 32'h0, 32'h0,
             2'b10, 5'd0, 5'd9, 32'h0, 32'hB);
        send(2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 32'h0,
             2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        send(2'b11, 2'b01, 2'b10, 5'd31, 5'd3, 32'h55, 32'h0, 32'h0, 32'h100,
             2'b10, 5'd0, 5'd31, 32'h0, 32'h108);
        send(2'b11, 2'b11, 2'b00, 5'd3, 5'd4, 32'h33, 32'h44, 32'h0, 32'h0,
             2'b11, 5'd3, 5'd4, 32'h33, 32'h44);
        send(2'b01, 2'b11, 2'b00, 5'd2, 5'd6, 32'h22, 32'h66, 32'h0, 32'h0,
             2'b01, 5'd2, 5'd0, 32'h22, 32'h0);
        idle();
        step();
        chk("cnt_conflict", 32'(retired_count), 32'(exp_cnt));

        // back-pressure: hold A for 3 stalled cycles with B waiting
        send(2'b01, 2'b01, 2'b00, 5'd10, 5'd0, 32'hAA, 32'h0, 32'h0, 32'h0,
             2'b01, 5'd10, 5'd0, 32'hAA, 32'h0);
        rf_stall = 1'b1;
        drive(2'b10, 2'b10, 2'b00, 5'd0, 5'd11, 32'h0, 32'hBB, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", 32'(bus.in_ready), 32'h0);
            chk("stall_en", 32'(reg_write_en), 32'h0);
            chk("stall_dest0", 32'(reg_write_dest[4:0]), 32'd10);
            chk("stall_data0", reg_write_data[31:0], 32'hAA);
        end
        step();
        rf_stall = 1'b0;
        @(negedge clk);
        chk("unstall_ready", 32'(bus.in_ready), 32'h1);
        expect_wr(2'b10, 5'd0, 5'd11, 32'h0, 32'hBB);
        exp_cnt += 4'd1;
        step();
        idle();
        step();
        chk("cnt_stall", 32'(retired_count), 32'(exp_cnt));

        // flush beats stall and a valid input
        drive(2'b01, 2'b01, 2'b00, 5'd12, 5'd0, 32'hCC, 32'h0, 32'h0, 32'h0);
        step();
        flush = 1'b1;
        rf_stall = 1'b1;
        drive(2'b01, 2'b01, 2'b00, 5'd13, 5'd0, 32'hDD, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("flush_en", 32'(reg_write_en), 32'h0);
        step();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_empty", 32'(bus.in_ready), 32'h1);
        step();
        rf_stall = 1'b0;
        step();
        step();
        chk("cnt_flush", 32'(retired_count), 32'(exp_cnt));

        // reset with a bundle held: no write, counter cleared
        drive(2'b11, 2'b11, 2'b00, 5'd14, 5'd15, 32'hE0, 32'hE1, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("midrst_en", 32'(reg_write_en), 32'h0);
        step();
        rst = 1'b1;
        rf_stall = 1'b1;
        exp_cnt = 4'd0;
        @(negedge clk);
        chk("midrst_cnt", 32'(retired_count), 32'h0);
        chk("midrst_empty", 32'(bus.in_ready), 32'h1);
        step();
        rf_stall = 1'b0;

        // counter wrap: 15 retired, then +2 -> 1
        for (int k = 0; k < 7; k++) begin
            send(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0,
                 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        end
        send(2'b01, 2'b00, 2'b00, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0,
             2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        idle();
        step();
        chk("cnt_15", 32'(retired_count), 32'd15);
        send(2'b11, 2'b00, 2'b00, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0,
             2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        idle();
        step();
        chk("cnt_wrap", 32'(retired_count), 32'd1);
        chk("cnt_model", 32'(retired_count), 32'(exp_cnt));

        step();
        step();
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_writeback_pipe.md
Name: wb_writeback_pipe

Overview:
Parametrised multi-lane writeback stage: registers up to LANES results from MEM per cycle and drives LANES register-file write ports one cycle later. Handles branch-link redirection to the link register, zero-register suppression, same-destination conflicts within a bundle, register-file back-pressure and pipeline flush. Keeps a retired-instruction counter for performance monitoring. Sits between the memory stage and the register file / forwarding network.

Parameters:
LANES, 2, issue width (1..4)
DATA_W, 32, result / PC width
REG_AW, 5, register address width
LINK_REG, 31, link register index for branch-link
LINK_OFFSET, 8, added to lane PC for link value (delay slot)
CNT_W, 32, retired counter width

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  LANES  lane i carries an instruction
in_ready  out  1  stage can accept a bundle this cycle
in_result  in  LANES*DATA_W  ALU/load result, lane i at [i*DATA_W +: DATA_W]
in_pc  in  LANES*DATA_W  instruction PC per lane
in_dest  in  LANES*REG_AW  destination register per lane
in_write_en  in  LANES  lane writes a register
in_branch_link  in  LANES  lane is a branch-and-link
flush  in  1  kill the held bundle
rf_stall  in  1  register file cannot accept writes this cycle
reg_write_en  out  LANES  per-port write enable
reg_write_dest  out  LANES*REG_AW  per-port write address
reg_write_data  out  LANES*DATA_W  per-port write data
retired_count  out  CNT_W  count of committed instructions

Behaviour:
- Reset (rst==0 at clk edge): stage_valid=0, all held lane fields 0, retired_count=0. reg_write_en=0 for as long as rst is low. in_ready=1 after reset.
- Pipeline register, one bundle deep. in_ready = !stage_valid || !rf_stall. Combinational; it does not depend on in_valid.
- Accept: when in_ready && |in_valid && !flush, capture all lane fields. Set stage_valid=1. Latency: write ports are driven in the cycle after acceptance.
- Drain: when stage_valid && !rf_stall && !flush and nothing is accepted, clear stage_valid. Accept and drain in the same cycle replaces the bundle (back-to-back throughput 1 bundle/cycle).
- Lane resolution is combinational from held fields:
  - If branch_link[i]: dest=LINK_REG, data=pc[i]+LINK_OFFSET (mod 2^DATA_W), want[i]=1. This overrides write_en and dest.
  - Otherwise dest=dest[i], data=result[i], want[i]=write_en[i].
  - want[i] is forced to 0 if the lane is not valid or the resolved dest is 0.
  - Conflict: if want[i] && want[j], j>i, and the two resolved dests are equal, lane i is suppressed. The higher lane is younger and wins.
- Outputs: reg_write_en[i] = stage_valid && !rf_stall && !flush && want_resolved[i]. Dest/data ports always show resolved values; they are don't-care when en=0.
- rf_stall: holds the bundle and all its fields, gates all enables, in_ready=0 while stage_valid. No write is lost or duplicated.
- flush: gates all enables in the same cycle, clears stage_valid at the edge, blocks acceptance that cycle. It wins over rf_stall and over in_valid. Flush with stage empty has no effect.
- retired_count: on every cycle a bundle drains (stage_valid && !rf_stall && !flush), add popcount of the held valid lanes. This includes lanes with no write, suppressed lanes and dest 0. Wraps modulo 2^CNT_W. It is not incremented on flush.
- Reset mid-stall or mid-bundle: the bundle is discarded with no write and the counter is cleared.

Test Plan:
- Single lane (LANES=2, lane0 only): result=0x1234, dest=5, we=1 at cycle 0 -> cycle 1: en=2'b01, dest0=5, data0=0x1234; retired_count=1 at cycle 2.
- Branch link: lane1 pc=0x8000_0010, branch_link=1, we=0, dest=7 -> en[1]=1, dest1=31, data1=0x8000_0018. Repeat with pc=0xFFFF_FFFC -> data1=0x0000_0004.
- Conflict and zero dest: lane0 dest=9 data=0xA, lane1 dest=9 data=0xB, both we -> only en[1], data1=0xB, retired +2. Then lane0 dest=0 we=1 -> en=0, retired +1.
- Back-pressure: bundle held, rf_stall=1 for 3 cycles -> en=0, in_ready=0, fields stable. Stall drops -> exactly one write, and a new bundle is accepted that same cycle.
- Flush: bundle held, flush=1 with rf_stall=1 and in_valid=1 -> no write, stage empty next cycle, input not captured, counter unchanged.
- Reset: bundle held, rst=0 for one edge -> en=0 during reset, retired_count=0, stage_valid=0. CNT_W=4 saturation check: 15 retired then +2 -> wraps to 1.
